// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// holds one fetched word until the IF/ID register consumes it.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_ID_write,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [29:0] fourPC,
    output logic [31:0] instruction
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [29:0] r_pc, w_pc_nxt;
    logic [29:0] r_tgt, w_tgt_nxt;
    logic [31:0] r_buf, w_buf_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC[31:2];
            r_tgt   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    // Redirect takes priority in every state; S_DROP keeps the request and
    // address stable until the abandoned fetch is acked, then jumps to r_tgt.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;
        w_buf_nxt   = r_buf;
        case (r_state)
            S_REQ: begin
                if (redirect && imem_ack) begin
                    w_pc_nxt = redirect_pc;
                end else if (redirect) begin
                    w_tgt_nxt   = redirect_pc;
                    w_state_nxt = S_DROP;
                end else if (imem_ack) begin
                    w_buf_nxt   = imem_rdata;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (IF_ID_write) begin
                    w_pc_nxt    = r_pc + 30'd1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    w_pc_nxt    = redirect ? redirect_pc : r_tgt;
                    w_state_nxt = S_REQ;
                end else if (redirect) begin
                    w_tgt_nxt = redirect_pc;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    assign imem_req    = ((r_state == S_REQ) || (r_state == S_DROP)) && !rst;
    assign imem_addr   = r_pc;
    assign fetch_valid = (r_state == S_HOLD);
    assign instruction = fetch_valid ? r_buf : '0;
    assign fourPC      = r_pc + 30'd1;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: table-driven fetch vectors with a scoreboard, plus
// hand-written redirect, wrap-around and reset sequences.
module tb_if_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, IF_ID_write, redirect;
    logic [29:0] redirect_pc;
    logic        imem_req, imem_ack, fetch_valid;
    logic [29:0] imem_addr, fourPC;
    logic [31:0] imem_rdata, instruction;

    logic        b_if_id, b_req, b_valid;
    logic [29:0] b_addr, b_fpc;
    logic [31:0] b_rdata, b_ins;

    int unsigned lat, wcnt;
    int          n_checks, n_fail;

    typedef struct {
        logic [29:0] fpc;
        logic [31:0] ins;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [29:0] addr;
        int unsigned lat;
        int unsigned stall;
        logic [29:0] fpc;
        logic [31:0] ins;
    } vec_t;
    vec_t vt[6];

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b00} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: acks after 'lat' waiting cycles of an outstanding request.
    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = mem_word(imem_addr);
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end
    assign b_rdata = mem_word(b_addr);

    if_fetch #(.RESET_PC(32'h0000_3000)) u_dut (
        .clk(clk), .rst(rst), .IF_ID_write(IF_ID_write), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_valid(fetch_valid),
        .fourPC(fourPC), .instruction(instruction)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst), .IF_ID_write(b_if_id), .redirect(1'b0),
        .redirect_pc(30'h0), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_req), .imem_rdata(b_rdata), .fetch_valid(b_valid),
        .fourPC(b_fpc), .instruction(b_ins)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered in the low phase of the first request cycle; leaves in the low
    // phase of the cycle after the held word is consumed or redirected away.
    task automatic do_fetch(input string tag, input logic [29:0] addr, input int unsigned l,
                            input int unsigned stall, input logic [29:0] efpc,
                            input logic [31:0] eins, input bit rd, input logic [29:0] rpc);
        exp_t e;
        int   n;
        lat = l;
        #1;
        check($sformatf("%s_req", tag), 32'(imem_req), 32'd1);
        check($sformatf("%s_addr", tag), 32'(imem_addr), 32'(addr));
        n = 0;
        while (!imem_ack && n < 20) begin
            @(posedge clk); @(negedge clk); #1;
            check($sformatf("%s_addr_stable", tag), 32'(imem_addr), 32'(addr));
            check($sformatf("%s_novalid", tag), 32'(fetch_valid), 32'd0);
            n++;
        end
        if (!imem_ack) begin
            n_checks++; n_fail++;
            $display("FAIL %s_ack_timeout: got no ack expected ack within 20 cycles", tag);
        end else begin
            sb.push_back('{efpc, eins});
        end
        @(posedge clk); @(negedge clk); #1;
        check($sformatf("%s_valid", tag), 32'(fetch_valid), 32'd1);
        check($sformatf("%s_req_low", tag), 32'(imem_req), 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s_fourPC", tag), 32'(fourPC), 32'(e.fpc));
            check($sformatf("%s_instr", tag), instruction, e.ins);
        end else begin
            n_checks++; n_fail++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
        end
        for (int unsigned s = 0; s < stall; s++) begin
            @(posedge clk); @(negedge clk); #1;
            check($sformatf("%s_stall_valid", tag), 32'(fetch_valid), 32'd1);
            check($sformatf("%s_stall_fourPC", tag), 32'(fourPC), 32'(efpc));
            check($sformatf("%s_stall_instr", tag), instruction, eins);
            check($sformatf("%s_stall_req", tag), 32'(imem_req), 32'd0);
        end
        if (rd) begin
            redirect    = 1'b1;
            redirect_pc = rpc;
        end
        IF_ID_write = 1'b1;
        @(posedge clk); #1;
        IF_ID_write = 1'b0;
        redirect    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; IF_ID_write = 1'b0; redirect = 1'b0; redirect_pc = '0;
        b_if_id = 1'b0; lat = 0;

        vt[0] = '{30'h0C00, 0, 0, 30'h0C01, mem_word(30'h0C00)};
        vt[1] = '{30'h0C01, 0, 0, 30'h0C02, mem_word(30'h0C01)};
        vt[2] = '{30'h0C02, 0, 3, 30'h0C03, mem_word(30'h0C02)};
        vt[3] = '{30'h0C03, 2, 0, 30'h0C04, mem_word(30'h0C03)};
        vt[4] = '{30'h0C04, 1, 1, 30'h0C05, mem_word(30'h0C04)};
        vt[5] = '{30'h0C05, 0, 0, 30'h0C06, mem_word(30'h0C05)};

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_addr", 32'(imem_addr), 32'h0000_0C00);
        check("rst_wrap_addr", 32'(b_addr), 32'h3FFF_FFFF);
        check("rst_wrap_req", 32'(b_req), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            do_fetch($sformatf("v%0d", i), vt[i].addr, vt[i].lat, vt[i].stall,
                     vt[i].fpc, vt[i].ins, 1'b0, 30'h0);

        // Redirect while holding, with IF_ID_write also high: redirect wins.
        do_fetch("redir_hold", 30'h0C06, 0, 1, 30'h0C07, mem_word(30'h0C06), 1'b1, 30'h0C10);
        #1;
        check("redir_hold_valid", 32'(fetch_valid), 32'd0);
        check("redir_hold_instr", instruction, 32'h0);
        check("redir_hold_addr", 32'(imem_addr), 32'h0000_0C10);
        check("redir_hold_req", 32'(imem_req), 32'd1);
        do_fetch("after_redir", 30'h0C10, 0, 0, 30'h0C11, mem_word(30'h0C10), 1'b0, 30'h0);

        // Redirect with a slow ack: two targets, latest wins, old data dropped.
        lat = 3;
        #1;
        check("drop_addr0", 32'(imem_addr), 32'h0000_0C11);
        redirect = 1'b1; redirect_pc = 30'h0C30;
        @(posedge clk); #1;
        redirect_pc = 30'h0C40;
        @(negedge clk); #1;
        check("drop_req1", 32'(imem_req), 32'd1);
        check("drop_addr1", 32'(imem_addr), 32'h0000_0C11);
        check("drop_valid1", 32'(fetch_valid), 32'd0);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk); #1;
        n = 0;
        while (!imem_ack && n < 10) begin
            check("drop_addr_wait", 32'(imem_addr), 32'h0000_0C11);
            check("drop_valid_wait", 32'(fetch_valid), 32'd0);
            @(posedge clk); @(negedge clk); #1;
            n++;
        end
        if (!imem_ack) begin
            n_checks++; n_fail++;
            $display("FAIL drop_ack_timeout: got no ack expected ack within 10 cycles");
        end
        check("drop_addr_ack", 32'(imem_addr), 32'h0000_0C11);
        @(posedge clk); @(negedge clk); #1;
        check("drop_done_valid", 32'(fetch_valid), 32'd0);
        check("drop_done_addr", 32'(imem_addr), 32'h0000_0C40);
        check("drop_done_req", 32'(imem_req), 32'd1);
        do_fetch("after_drop", 30'h0C40, 1, 0, 30'h0C41, mem_word(30'h0C40), 1'b0, 30'h0);

        // Redirect in the same cycle as the ack: data dropped, stay requesting.
        lat = 0;
        #1;
        check("redir_ack_addr0", 32'(imem_addr), 32'h0000_0C41);
        redirect = 1'b1; redirect_pc = 30'h0C50;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk); #1;
        check("redir_ack_valid", 32'(fetch_valid), 32'd0);
        check("redir_ack_addr", 32'(imem_addr), 32'h0000_0C50);
        check("redir_ack_req", 32'(imem_req), 32'd1);

        // PC wrap on the instance reset to 0xFFFF_FFFC.
        check("wrap_valid", 32'(b_valid), 32'd1);
        check("wrap_fourPC", 32'(b_fpc), 32'h0);
        check("wrap_instr", b_ins, mem_word(30'h3FFF_FFFF));
        b_if_id = 1'b1;
        @(posedge clk); #1;
        b_if_id = 1'b0;
        @(negedge clk); #1;
        check("wrap_next_req", 32'(b_req), 32'd1);
        check("wrap_next_addr", 32'(b_addr), 32'h0);

        // Reset while holding a word.
        check("hold_pre_rst_valid", 32'(fetch_valid), 32'd1);
        check("hold_pre_rst_instr", instruction, mem_word(30'h0C50));
        check("hold_pre_rst_fourPC", 32'(fourPC), 32'h0000_0C51);
        rst = 1'b1;
        #1;
        check("hold_rst_req", 32'(imem_req), 32'd0);
        @(posedge clk); @(negedge clk); #1;
        check("hold_rst_valid", 32'(fetch_valid), 32'd0);
        check("hold_rst_instr", instruction, 32'h0);
        check("hold_rst_addr", 32'(imem_addr), 32'h0000_0C00);

        // Reset abandoning an outstanding request.
        lat = 3;
        rst = 1'b0;
        #1;
        check("pend_req", 32'(imem_req), 32'd1);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        check("pend_rst_req", 32'(imem_req), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        do_fetch("post_rst0", 30'h0C00, 0, 0, 30'h0C01, mem_word(30'h0C00), 1'b0, 30'h0);
        do_fetch("post_rst1", 30'h0C01, 0, 0, 30'h0C02, mem_word(30'h0C01), 1'b0, 30'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
